// File: rtl/ltc_multi_phase.sv
// ltc_multi_phase: round-robin traffic light controller for NPH road phases.
// Each phase gets GREEN -> YELLOW -> ALLRED, with an optional pedestrian WALK
// interval inserted after ALLRED. Timing is in whole seconds derived from a
// free-running prescaler; all lamp outputs are registered and one-hot per phase.
module ltc_multi_phase #(
    parameter int CLK_HZ      = 1000,
    parameter int NPH         = 2,
    parameter int PW          = 1,
    parameter int SEC_W       = 8,
    parameter int GREEN_S     = 30,
    parameter int YELLOW_S    = 3,
    parameter int ALLRED_S    = 1,
    parameter int PED_S       = 10,
    parameter int MIN_GREEN_S = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             N,
    output logic [NPH-1:0]   grn,
    output logic [NPH-1:0]   yel,
    output logic [NPH-1:0]   red,
    output logic             walk,
    output logic [PW-1:0]    phase,
    output logic [SEC_W-1:0] sec_left,
    output logic             ped_pending
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SEC_MAX = (2 ** SEC_W) - 1;

    // Out-of-range parameters are rejected at elaboration.
    if (CLK_HZ < 1 || NPH < 2 || PW < $clog2(NPH) ||
        GREEN_S < 1 || YELLOW_S < 1 || ALLRED_S < 1 || PED_S < 1 ||
        MIN_GREEN_S < 1 || MIN_GREEN_S > GREEN_S ||
        GREEN_S > SEC_MAX || YELLOW_S > SEC_MAX ||
        ALLRED_S > SEC_MAX || PED_S > SEC_MAX) begin : g_bad_params
        $error("ltc_multi_phase: parameter out of range");
    end

    localparam logic [CW-1:0]    TC        = CW'(CLK_HZ - 1);
    localparam logic [PW-1:0]    LAST_PH   = PW'(NPH - 1);
    localparam logic [SEC_W-1:0] GREEN_L   = SEC_W'(GREEN_S);
    localparam logic [SEC_W-1:0] YELLOW_L  = SEC_W'(YELLOW_S);
    localparam logic [SEC_W-1:0] ALLRED_L  = SEC_W'(ALLRED_S);
    localparam logic [SEC_W-1:0] PED_L     = SEC_W'(PED_S);
    // Elapsed green seconds = GREEN_S - sec_left + 1; the cut is allowed once
    // that reaches MIN_GREEN_S, i.e. once sec_left has fallen to this value.
    localparam logic [SEC_W-1:0] CUT_LEFT  = SEC_W'(GREEN_S + 1 - MIN_GREEN_S);

    typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_WALK} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             tick;
    logic [PW-1:0]    phase_nxt;
    logic [SEC_W-1:0] sec_nxt;
    logic             ped_nxt;
    logic [NPH-1:0]   grn_nxt, yel_nxt, red_nxt;
    logic             walk_nxt;

    assign tick = (cnt == TC);

    // State register: prescaler, FSM state, counters and registered lamps.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            cnt         <= '0;
            state       <= S_GREEN;
            phase       <= '0;
            sec_left    <= GREEN_L;
            ped_pending <= 1'b0;
            grn         <= NPH'(1);
            yel         <= '0;
            red         <= ~NPH'(1);
            walk        <= 1'b0;
        end else begin
            cnt         <= tick ? '0 : cnt + 1'b1;
            state       <= state_nxt;
            phase       <= phase_nxt;
            sec_left    <= sec_nxt;
            ped_pending <= ped_nxt;
            grn         <= grn_nxt;
            yel         <= yel_nxt;
            red         <= red_nxt;
            walk        <= walk_nxt;
        end
    end

    // Next-state logic: second countdown, pedestrian cut and phase rotation.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_nxt = state;
        phase_nxt = phase;
        sec_nxt   = sec_left;
        ped_nxt   = ped_pending;

        if (N && state != S_WALK) ped_nxt = 1'b1;

        if (tick) begin
            sec_nxt = sec_left - 1'b1;
            unique case (state)
                S_GREEN: begin
                    if (sec_left == 1 || (ped_pending && sec_left <= CUT_LEFT)) begin
                        state_nxt = S_YELLOW;
                        sec_nxt   = YELLOW_L;
                    end
                end
                S_YELLOW: begin
                    if (sec_left == 1) begin
                        state_nxt = S_ALLRED;
                        sec_nxt   = ALLRED_L;
                    end
                end
                S_ALLRED: begin
                    if (sec_left == 1) begin
                        if (ped_pending) begin
                            // Entering WALK consumes the request, even if N is high now.
                            state_nxt = S_WALK;
                            sec_nxt   = PED_L;
                            ped_nxt   = 1'b0;
                        end else begin
                            state_nxt = S_GREEN;
                            sec_nxt   = GREEN_L;
                            phase_nxt = (phase == LAST_PH) ? '0 : phase + 1'b1;
                        end
                    end
                end
                S_WALK: begin
                    if (sec_left == 1) begin
                        state_nxt = S_GREEN;
                        sec_nxt   = GREEN_L;
                        phase_nxt = (phase == LAST_PH) ? '0 : phase + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode of the upcoming state, registered above so lamps never glitch.
    always_comb begin
        logic [NPH-1:0] sel;
        sel      = NPH'(1) << phase_nxt;
        grn_nxt  = '0;
        yel_nxt  = '0;
        red_nxt  = '1;
        walk_nxt = 1'b0;
        unique case (state_nxt)
            S_GREEN: begin
                grn_nxt = sel;
                red_nxt = ~sel;
            end
            S_YELLOW: begin
                yel_nxt = sel;
                red_nxt = ~sel;
            end
            S_WALK:   walk_nxt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ltc_multi_phase.sv
// Testbench for ltc_multi_phase: directed scenarios plus random pedestrian
// traffic, checked through a scoreboard fed by an elapsed-time reference model.
module tb_ltc_multi_phase;

    localparam int CLK_HZ = 10, NPH = 3, PW = 2, SEC_W = 8;
    localparam int GREEN_S = 5, YELLOW_S = 2, ALLRED_S = 1, PED_S = 3, MIN_GREEN_S = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             N   = 1'b0;
    logic [NPH-1:0]   grn, yel, red;
    logic             walk;
    logic [PW-1:0]    phase;
    logic [SEC_W-1:0] sec_left;
    logic             ped_pending;

    int checks = 0;
    int errors = 0;

    ltc_multi_phase #(
        .CLK_HZ(CLK_HZ), .NPH(NPH), .PW(PW), .SEC_W(SEC_W),
        .GREEN_S(GREEN_S), .YELLOW_S(YELLOW_S), .ALLRED_S(ALLRED_S),
        .PED_S(PED_S), .MIN_GREEN_S(MIN_GREEN_S)
    ) dut (
        .clk(clk), .rst(rst), .N(N),
        .grn(grn), .yel(yel), .red(red), .walk(walk),
        .phase(phase), .sec_left(sec_left), .ped_pending(ped_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NPH-1:0]   grn, yel, red;
        logic             walk;
        logic [PW-1:0]    phase;
        logic [SEC_W-1:0] sec;
        logic             ped;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode is the interval being shown, elapsed counts whole
    // seconds spent in it, edges counts clock edges since the last reset.
    localparam int M_GREEN = 0, M_YELLOW = 1, M_ALLRED = 2, M_WALK = 3;
    int m_mode, m_ph, m_elapsed, m_edges;
    bit m_ped;

    function automatic int dur(input int mode);
        case (mode)
            M_GREEN:  return GREEN_S;
            M_YELLOW: return YELLOW_S;
            M_ALLRED: return ALLRED_S;
            default:  return PED_S;
        endcase
    endfunction

    function automatic void model_step(input bit n_in, input bit rst_in);
        bit old_ped;
        int next_mode;
        if (!rst_in) begin
            m_mode = M_GREEN; m_ph = 0; m_elapsed = 0; m_edges = 0; m_ped = 0;
            return;
        end
        m_edges++;
        old_ped   = m_ped;
        next_mode = m_mode;
        if (n_in && m_mode != M_WALK) m_ped = 1;
        if (m_edges % CLK_HZ == 0) begin
            m_elapsed++;
            if (m_mode == M_GREEN &&
                (m_elapsed == GREEN_S || (old_ped && m_elapsed >= MIN_GREEN_S)))
                next_mode = M_YELLOW;
            else if (m_mode == M_YELLOW && m_elapsed == YELLOW_S)
                next_mode = M_ALLRED;
            else if (m_mode == M_ALLRED && m_elapsed == ALLRED_S)
                next_mode = old_ped ? M_WALK : M_GREEN;
            else if (m_mode == M_WALK && m_elapsed == PED_S)
                next_mode = M_GREEN;
            if (next_mode != m_mode) begin
                if (next_mode == M_WALK) m_ped = 0;
                if (next_mode == M_GREEN) m_ph = (m_ph + 1) % NPH;
                m_mode    = next_mode;
                m_elapsed = 0;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.grn = '0; e.yel = '0; e.red = '0;
        for (int i = 0; i < NPH; i++) begin
            if (m_mode == M_GREEN && i == m_ph)       e.grn[i] = 1'b1;
            else if (m_mode == M_YELLOW && i == m_ph) e.yel[i] = 1'b1;
            else                                      e.red[i] = 1'b1;
        end
        e.walk  = (m_mode == M_WALK);
        e.phase = PW'(m_ph);
        e.sec   = SEC_W'(dur(m_mode) - m_elapsed);
        e.ped   = m_ped;
        return e;
    endfunction

    // One clock of stimulus: apply inputs, predict the post-edge outputs,
    // then return just after the edge.
    task automatic cyc(input bit n_in, input bit rst_in);
        N   = n_in;
        rst = rst_in;
        model_step(n_in, rst_in);
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are presented every cycle, compared away from the edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("grn", 32'(grn), 32'(e.grn));
            check("yel", 32'(yel), 32'(e.yel));
            check("red", 32'(red), 32'(e.red));
            check("walk", 32'(walk), 32'(e.walk));
            check("phase", 32'(phase), 32'(e.phase));
            check("sec_left", 32'(sec_left), 32'(e.sec));
            check("ped_pending", 32'(ped_pending), 32'(e.ped));
        end
    end

    initial begin
        // 1. Reset held for two cycles.
        cyc(0, 0);
        cyc(0, 0);
        check("rst_grn", 32'(grn), 32'b001);
        check("rst_red", 32'(red), 32'b110);
        check("rst_sec", 32'(sec_left), 32'd5);

        // 2. Free run, full rotation of 240 cycles.
        for (int i = 1; i <= 240; i++) begin
            cyc(0, 1);
            if (i == 50)  check("run_yel0", 32'(yel), 32'b001);
            if (i == 70)  check("run_allred", 32'(red), 32'b111);
            if (i == 80)  check("run_grn1", 32'(grn), 32'b010);
            if (i == 240) check("run_wrap", 32'(grn), 32'b001);
        end

        // 3. Early request: cut at the second tick, then WALK.
        cyc(0, 0);
        for (int i = 1; i <= 80; i++) begin
            cyc(i == 5, 1);
            if (i == 5)  check("ped_latched", 32'(ped_pending), 32'd1);
            if (i == 19) check("cut_not_yet", 32'(grn), 32'b001);
            if (i == 20) check("cut_yel0", 32'(yel), 32'b001);
            if (i == 50) check("walk_on", 32'({walk, ped_pending, red}), 32'b10111);
            if (i == 80) check("walk_grn1", 32'(grn), 32'b010);
        end

        // 4a. Request after three elapsed seconds cuts at cycle 40.
        cyc(0, 0);
        for (int i = 1; i <= 60; i++) begin
            cyc(i == 35, 1);
            if (i == 40) check("cut40_yel", 32'({yel, sec_left}), {3'b001, 8'd2});
        end

        // 4b. Request in the last green second; 5. N held only during WALK.
        cyc(0, 0);
        for (int i = 1; i <= 170; i++) begin
            cyc(i == 45 || (i > 80 && i <= 110), 1);
            if (i == 49)  check("late_still_grn", 32'(grn), 32'b001);
            if (i == 50)  check("late_yel", 32'(yel), 32'b001);
            if (i == 80)  check("late_walk", 32'(walk), 32'd1);
            if (i == 110) check("walk_ignored", 32'(ped_pending), 32'd0);
            if (i == 160) check("yel1", 32'(yel), 32'b010);
        end
        // 6. Reset pulse mid-YELLOW1, then check the prescaler restarted.
        cyc(0, 0);
        check("midrst_grn", 32'({grn, sec_left}), {3'b001, 8'd5});
        for (int i = 1; i <= 40; i++) begin
            cyc(0, 1);
            if (i == 9)  check("midrst_pre", 32'(sec_left), 32'd5);
            if (i == 10) check("midrst_tick", 32'(sec_left), 32'd4);
        end

        // 7. Random pedestrian traffic with occasional resets.
        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(0, 24) == 0, $urandom_range(0, 599) != 0);

        @(negedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ltc_multi_phase.md
Name: ltc_multi_phase

Overview:
Parametrised successor to the two-road light controller with yellow/green decode. It drives NPH road phases in round-robin, with configurable green, yellow, all-red and pedestrian-walk durations in seconds. A pedestrian request N can cut green short after a minimum green time and inserts a walk interval. All lamp outputs are registered and one-hot per phase.

Parameters:
CLK_HZ, 1000, clk cycles per second (prescaler terminal count)
NPH, 2, number of road phases (>=2)
PW, 1, width of phase index (>= clog2(NPH))
SEC_W, 8, width of seconds countdown
GREEN_S, 30, green duration in seconds (>=1)
YELLOW_S, 3, yellow duration in seconds (>=1)
ALLRED_S, 1, all-red clearance in seconds (>=1)
PED_S, 10, walk duration in seconds (>=1)
MIN_GREEN_S, 5, minimum green before a pedestrian cut (1..GREEN_S)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
N  in  1  pedestrian request, level-sampled every clk, must be held >=1 cycle
grn  out  NPH  green lamp per phase
yel  out  NPH  yellow lamp per phase
red  out  NPH  red lamp per phase
walk  out  1  pedestrian walk lamp
phase  out  PW  phase currently served (GREEN/YELLOW) or last served (ALLRED/WALK)
sec_left  out  SEC_W  seconds remaining in current state
ped_pending  out  1  latched pedestrian request

Behaviour:
- One clock; rst is synchronous and active-low. rst=0 at a rising edge sets: state=GREEN, phase=0, sec_left=GREEN_S, prescaler=0, ped_pending=0, grn=1 (phase 0 only), yel=0, red=~1, walk=0. This also applies mid-operation in any state.
- Prescaler counts 0..CLK_HZ-1 and wraps. tick=1 for the cycle where count==CLK_HZ-1. The prescaler runs freely and is not cleared on state change, so every state lasts an integer number of ticks.
- States: GREEN, YELLOW, ALLRED, WALK.
- On tick, if sec_left>1, decrement. If sec_left==1, transition and load the new duration. Without a pedestrian cut, each state lasts exactly duration*CLK_HZ cycles.
- GREEN -> YELLOW on the normal expiry tick. Pedestrian cut: on a tick with ped_pending=1 and (GREEN_S-sec_left+1)>=MIN_GREEN_S, go to YELLOW at that tick.
- YELLOW -> ALLRED after YELLOW_S.
- ALLRED -> WALK if ped_pending=1. Otherwise ALLRED -> GREEN with phase=(phase+1) mod NPH.
- WALK -> GREEN with phase=(phase+1) mod NPH after PED_S.
- ped_pending is set on any clk edge with N=1 while state!=WALK, and cleared on the edge entering WALK. N during WALK is ignored. N=1 on the same edge as the ALLRED->WALK transition still enters WALK and leaves ped_pending=0.
- Lamp decode:
  - In GREEN/YELLOW, only phase p shows grn/yel; every other phase shows red.
  - In ALLRED/WALK, red=all ones and grn=yel=0.
  - walk=1 only in WALK.
  - For every phase, exactly one of grn/yel/red is 1 at all times.
- All outputs are registered and change only on the transition edge, never combinationally from N.
- Phase wrap: NPH-1 -> 0. When NPH is not a power of two, the phase index never exceeds NPH-1.
- No arithmetic overflow: durations must fit SEC_W; out-of-range parameters are a static error.

Test Plan:
Bench overrides CLK_HZ=10, NPH=3, PW=2, GREEN_S=5, YELLOW_S=2, ALLRED_S=1, PED_S=3, MIN_GREEN_S=2.
1. Reset: hold rst=0 for 2 cycles, then release -> grn=001, yel=000, red=110, walk=0, phase=0, sec_left=5, ped_pending=0.
2. Free run, N=0 -> GREEN0 for 50 cycles, YELLOW0 for 20 (yel=001), ALLRED for 10 (red=111), then GREEN1 (grn=010). Full rotation is 240 cycles and returns to phase=0 with grn=001.
3. N=1 for 1 cycle at cycle 5 after reset -> ped_pending=1. Cycle 10 tick (elapsed 1) no change; cycle 20 tick -> YELLOW0. Cycle 40 -> ALLRED. Cycle 50 -> WALK (walk=1, red=111, ped_pending=0). Cycle 80 -> GREEN1.
4. N pulse at cycle 35 (elapsed 3) -> YELLOW0 at cycle 40. N pulse in last green second -> same timing as no N, then WALK after ALLRED.
5. Hold N=1 only during WALK -> no second WALK: after GREEN1 and YELLOW1, ALLRED leads to GREEN2.
6. rst=0 for 1 cycle mid-YELLOW1 -> next edge shows reset values (grn=001, sec_left=5); prescaler restarts, next tick 10 cycles after release.
